// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//
// 8N1 serial receiver. The asynchronous rx pin is passed through a two-flop
// synchroniser. A falling edge on the synchronised line is treated as a
// candidate start bit and confirmed at mid-bit. The 8 data bits are then
// sampled LSB first at mid-bit, and the stop bit is checked.
//
// A good frame updates `data` and raises `valid` for one cycle. A frame with
// a low stop bit raises `frame_err` for one cycle and leaves `data`
// unchanged. After a framing error the receiver waits for the line to return
// high, so a held-low break never produces a frame.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line rate in bit/s (CLK_FREQ / BAUD_RATE must be >= 4)
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idles high
//   data       last correctly framed byte
//   valid      one-cycle pulse, data updated in the same cycle
//   frame_err  one-cycle pulse on a bad stop bit
//   busy       high whenever the receiver is not idle
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 27000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

  // Terminal counts: half a bit to reach mid start bit, a full bit between
  // subsequent mid-bit samples.
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_cfg
      $error("uart_rx: CLK_FREQ / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Synchroniser
  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;

  // FSM state and datapath registers
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;

  // Next-state values
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_valid_nxt;
  logic          w_ferr_nxt;

  logic          w_cnt_half;
  logic          w_cnt_full;

  // --------------------------------------------------------------------------
  // Input synchroniser; both stages reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s     = r_sync2;
  assign w_cnt_half = (r_cnt == CNT_HALF);
  assign w_cnt_full = (r_cnt == CNT_FULL);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end

      // Re-check the line at mid start bit; a line already back high was a
      // glitch and is dropped silently.
      S_START: begin
        if (w_cnt_half) begin
          w_cnt_nxt = '0;
          if (!w_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      // LSB arrives first: shifting right and inserting at the MSB leaves d0
      // in bit 0 after the eighth sample.
      S_DATA: begin
        if (w_cnt_full) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      // Returning to idle at mid stop bit leaves half a bit of margin to
      // catch a start bit that follows a one-bit stop with no idle gap.
      S_STOP: begin
        if (w_cnt_full) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      S_WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule
